multicycle_control: RTL

Multi-cycle control FSM for the MIPS datapath, the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles, sharing one ALU and one memory port. It adds BNE, J and JAL, and a ready/request memory handshake with a parametrised timeout. It sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_control.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, ALU op
// codes, FSM states and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_RETRY
    } state_t;

    // States that hold a memory request open and may therefore time out.
    function automatic logic isMemWait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for ready and flags a timeout on the
// last permitted wait cycle; MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_CNT_W   = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_ready,
    input  logic i_clear,
    output logic o_timeout
);

    localparam logic [TMO_CNT_W-1:0] LAST_COUNT =
        TMO_CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_active || i_ready || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (MEM_TIMEOUT != 0) && i_active && !i_ready &&
                       (r_count == LAST_COUNT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with a ready/request memory handshake and retry
// on timeout. Define CONTROL_ILLEGAL_TRAP_EN to trap illegal opcodes (sticky).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_CNT_W   = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          opcode_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_write_o,
    output logic                i_or_d_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_write_cond_eq_o,
    output logic                pc_write_cond_ne_o,
    output logic [1:0]          pc_src_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                reg_write_o,
    output logic                instr_done_o,
    output logic                mem_timeout_o,
    output logic                illegal_o
);

    state_t     r_state;
    state_t     r_savedState;
    state_t     w_nextState;
    logic       w_timeout;
    logic [2:0] w_aluOp;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_CNT_W   (TMO_CNT_W)
    ) u_waitTimer (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_active  (isMemWait(r_state)),
        .i_ready   (mem_ready_i),
        .i_clear   (w_nextState != r_state),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready_i) w_nextState = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                         w_nextState = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_nextState = S_EXEC_I;
                    OP_LW, OP_SW:                     w_nextState = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   w_nextState = S_BRANCH;
                    OP_J, OP_JAL:                     w_nextState = S_JUMP;
                    default:                          w_nextState = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   w_nextState = S_WB_R;
            S_EXEC_I:   w_nextState = S_WB_I;
            S_MEM_ADDR: w_nextState = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) w_nextState = S_WB_MEM;
            S_MEM_WR:   if (mem_ready_i) w_nextState = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_nextState = S_FETCH;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  w_nextState = S_ILLEGAL;
`else
            S_ILLEGAL:  w_nextState = S_FETCH;
`endif
            S_RETRY:    w_nextState = r_savedState;
            default:    w_nextState = S_FETCH;
        endcase
        if (w_timeout) w_nextState = S_RETRY;
    end

    // The saved state lets RETRY re-issue exactly the request that timed out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_FETCH;
            r_savedState <= S_FETCH;
        end else begin
            r_state <= w_nextState;
            if (w_timeout) r_savedState <= r_state;
        end
    end

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_illegal <= 1'b0;
        end else if (w_nextState == S_ILLEGAL) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_o = r_illegal;
`else
    assign illegal_o = 1'b0;
`endif

    always_comb begin
        mem_req_o          = 1'b0;
        mem_write_o        = 1'b0;
        i_or_d_o           = 1'b0;
        ir_write_o         = 1'b0;
        pc_write_o         = 1'b0;
        pc_write_cond_eq_o = 1'b0;
        pc_write_cond_ne_o = 1'b0;
        pc_src_o           = PC_SRC_ALU;
        alu_src_a_o        = 1'b0;
        alu_src_b_o        = SRC_B_RT;
        w_aluOp            = ALU_LUI;
        reg_dst_o          = REG_DST_RT;
        mem_to_reg_o       = MEM_TO_REG_ALUOUT;
        reg_write_o        = 1'b0;
        instr_done_o       = 1'b0;
        mem_timeout_o      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                w_aluOp     = ALU_ADD;
                pc_src_o    = PC_SRC_ALU;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = SRC_B_IMM_SH2;
                w_aluOp     = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_RT;
                w_aluOp     = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RD;
                mem_to_reg_o = MEM_TO_REG_ALUOUT;
                instr_done_o = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                case (opcode_i)
                    OP_ANDI: w_aluOp = ALU_AND;
                    OP_ORI:  w_aluOp = ALU_OR;
                    OP_LUI:  w_aluOp = ALU_LUI;
                    default: w_aluOp = ALU_ADD;
                endcase
            end
            S_WB_I: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RT;
                instr_done_o = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                w_aluOp     = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o    = 1'b1;
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = MEM_TO_REG_MDR;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o        = 1'b1;
                w_aluOp            = ALU_SUB;
                pc_src_o           = PC_SRC_ALUOUT;
                pc_write_cond_eq_o = (opcode_i == OP_BEQ);
                pc_write_cond_ne_o = (opcode_i == OP_BNE);
                instr_done_o       = 1'b1;
            end
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_src_o     = PC_SRC_JUMP;
                instr_done_o = 1'b1;
                if (opcode_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = REG_DST_RA;
                    mem_to_reg_o = MEM_TO_REG_PC;
                end
            end
`ifndef CONTROL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  instr_done_o = 1'b1;
`endif
            S_RETRY:    mem_timeout_o = 1'b1;
            default: ;
        endcase
    end

    assign alu_op_o = ALU_OP_W'(w_aluOp);

endmodule
